pipereg_skid: RTL and testbench
===============================

Name: pipereg_skid

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- One generic stage register with a valid/ready handshake and a 2-entry skid buffer, so backpressure does not need a combinational path from the downstream stage to the upstream stage.
- Fields are split into a data bundle and a control bundle. The control bundle reads as zero (NOP: no write-enable, no store) whenever the stage holds no valid instruction.
- Has a flush, plus saturating stall and flush-drop counters for performance debug.

Parameters:
DATA_W, 96, width of the datapath bundle (operands, immediate, PC etc. concatenated by the instantiating stage)
CTRL_W, 16, width of the control bundle (ALU op, wr_en, dm_select etc.); forced to 0 when not valid
CNT_W, 16, width of the stall and drop performance counters

Ports:
clk  in  1  clock; all state updates on posedge
nrst  in  1  reset; synchronous, active-low
flush  in  1  discard all held entries and any same-cycle input
in_valid  in  1  upstream has an instruction
in_data  in  DATA_W  upstream data bundle
in_ctrl  in  CTRL_W  upstream control bundle
in_ready  out  1  stage can accept; decoded from state register only
out_valid  out  1  stage presents an instruction
out_data  out  DATA_W  data bundle of head entry
out_ctrl  out  CTRL_W  control bundle of head entry; 0 when out_valid=0
out_ready  in  1  downstream accepts
occupancy  out  2  number of held entries, 0..2
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
drop_cnt  out  CNT_W  valid entries discarded by flush, saturating

Behaviour:
- Storage: head entry (main) and second entry (skid), each holding data and ctrl. State is EMPTY, FULL or SKID.
- Decoded outputs:
  - occupancy = 0, 1 or 2 for EMPTY, FULL or SKID respectively.
  - in_ready = (state != SKID).
  - out_valid = (state != EMPTY).
  - out_data/out_ctrl come from the main entry.
  - No combinational path from out_ready or in_valid to any output.
- Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready. Latency is 1 cycle, so an input accepted in cycle N is visible on out_* in cycle N+1 when the stage was EMPTY, or was FULL with out_xfer.
- Priority order: reset > flush > normal operation.
- Reset (nrst=0 at posedge):
  - State goes to EMPTY; main, skid, stall_cnt and drop_cnt are all cleared to 0.
  - Next cycle: out_valid=0, out_data=0, out_ctrl=0, in_ready=1, occupancy=0.
- Reset mid-operation: held entries are lost; drop_cnt is not incremented (it is cleared).
- Flush (nrst=1, flush=1):
  - State goes to EMPTY; main and skid data/ctrl are zeroed.
  - Any in_xfer that cycle is discarded; an out_xfer that cycle still counts as consumed by downstream.
  - drop_cnt += occupancy (saturating), minus 1 if out_xfer occurred that cycle.
- Transitions (no flush):
  - EMPTY: in_xfer → main<=in, FULL.
  - FULL, in_xfer & out_xfer → main<=in, stay FULL.
  - FULL, in_xfer & !out_xfer → skid<=in, SKID.
  - FULL, !in_xfer & out_xfer → main<=0, EMPTY.
  - FULL, neither → hold.
  - SKID: out_xfer → main<=skid, skid<=0, FULL; else hold. No in_xfer is possible in SKID.
- Empty zeroing: any transition to EMPTY writes 0 to the main data and ctrl, so the bubble is a NOP.
- Ordering: strict FIFO; an entry is never duplicated or reordered.
- Holding entries: both held entries stay bit-stable while out_ready=0.
- stall_cnt: increments each cycle out_valid & !out_ready (flush cycles included). Saturates at 2^CNT_W-1 with no wrap. Unaffected by flush.
- drop_cnt: saturates at 2^CNT_W-1 with no wrap.

Test Plan:
- Reset then stream: nrst=0 for 2 cycles, then in_valid=1 with in_ctrl=16'h00A5, data=1,2,3 on consecutive cycles, out_ready=1 → out_valid rises 1 cycle later; out_data shows 1,2,3 on consecutive cycles; in_ready stays 1; occupancy=1.
- Backpressure fill: out_ready=0, push data=10 then 11 → occupancy 1 then 2; in_ready=0 after the second push; out_data stays 10; in_valid=1 with data=12 is not accepted; stall_cnt increments every cycle.
- Drain: from SKID (10,11) raise out_ready=1 for 2 cycles with in_valid=0 → out_data 10 then 11, then out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
- Flush: SKID holding 20,21, assert flush with in_valid=1 data=22 and out_ready=0 → next cycle EMPTY, out_ctrl=0, drop_cnt +=2, 22 never appears; in_ready=1.
- Counter saturation: CNT_W=4, hold out_valid=1 & out_ready=0 for 20 cycles → stall_cnt stops at 15.
- Reset mid-stall: SKID state, pull nrst=0 for 1 cycle → all outputs 0, in_ready=1, stall_cnt=0, drop_cnt=0.

Source files
------------

// File: rtl/pipereg_skid.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pipereg_skid: generic pipeline stage register with a 2-entry skid buffer |
// | Rev 1.0 - initial release                                                |
// +------------------------------------------------------------------------+
module pipereg_skid #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state, state_next;
  logic [DATA_W-1:0]   main_data, main_data_next;
  logic [CTRL_W-1:0]   main_ctrl, main_ctrl_next;
  logic [DATA_W-1:0]   skid_data, skid_data_next;
  logic [CTRL_W-1:0]   skid_ctrl, skid_ctrl_next;
  logic [CNT_W-1:0]    stall_q, stall_next;
  logic [CNT_W-1:0]    drop_q, drop_next;

  logic                in_xfer;
  logic                out_xfer;
  logic [1:0]          drop_inc;
  logic [CNT_W:0]      drop_sum;

  // Every output is decoded from registers only, so out_ready never ripples upstream.
  assign in_ready  = (state != SKID);
  assign out_valid = (state != EMPTY);
  assign occupancy = (state == SKID) ? 2'd2 : ((state == FULL) ? 2'd1 : 2'd0);
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign stall_cnt = stall_q;
  assign drop_cnt  = drop_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // An entry consumed downstream in the flush cycle is not counted as dropped.
  assign drop_inc = occupancy - {1'b0, out_xfer};
  assign drop_sum = {1'b0, drop_q} + {{(CNT_W-1){1'b0}}, drop_inc};

  always_comb begin
    state_next     = state;
    main_data_next = main_data;
    main_ctrl_next = main_ctrl;
    skid_data_next = skid_data;
    skid_ctrl_next = skid_ctrl;
    stall_next     = stall_q;
    drop_next      = drop_q;

    if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
      stall_next = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    if (flush) begin
      state_next     = EMPTY;
      main_data_next = '0;
      main_ctrl_next = '0;
      skid_data_next = '0;
      skid_ctrl_next = '0;
      drop_next      = drop_sum[CNT_W] ? CNT_MAX : drop_sum[CNT_W-1:0];
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_data_next = in_data;
            main_ctrl_next = in_ctrl;
            state_next     = FULL;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            main_data_next = in_data;
            main_ctrl_next = in_ctrl;
          end else if (in_xfer) begin
            skid_data_next = in_data;
            skid_ctrl_next = in_ctrl;
            state_next     = SKID;
          end else if (out_xfer) begin
            // Drained bubble reads as a NOP.
            main_data_next = '0;
            main_ctrl_next = '0;
            state_next     = EMPTY;
          end
        end
        SKID: begin
          if (out_xfer) begin
            main_data_next = skid_data;
            main_ctrl_next = skid_ctrl;
            skid_data_next = '0;
            skid_ctrl_next = '0;
            state_next     = FULL;
          end
        end
        default: begin
          state_next     = EMPTY;
          main_data_next = '0;
          main_ctrl_next = '0;
          skid_data_next = '0;
          skid_ctrl_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      stall_q   <= '0;
      drop_q    <= '0;
    end else begin
      state     <= state_next;
      main_data <= main_data_next;
      main_ctrl <= main_ctrl_next;
      skid_data <= skid_data_next;
      skid_ctrl <= skid_ctrl_next;
      stall_q   <= stall_next;
      drop_q    <= drop_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipereg_skid.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pipereg_skid: scoreboard bench for pipereg_skid                      |
// | Rev 1.0 - initial release                                                |
// +------------------------------------------------------------------------+
module tb_pipereg_skid;

  localparam int DW   = 96;
  localparam int CW   = 16;
  localparam int NW   = 4;
  localparam int CMAX = 15;

  logic          clk;
  logic          nrst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_ready;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] drop_cnt;

  pipereg_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .nrst(nrst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ctrl(out_ctrl), .out_ready(out_ready),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  // Reference: a FIFO of at most 2 held instructions plus two saturating counters.
  ent_t exp_q[$];
  int   stall_m = 0;
  int   drop_m  = 0;
  int   pops    = 0;
  int   pops_seen = 0;
  bit   mon_en  = 1'b0;
  int   passed  = 0;
  int   total   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares presented outputs, pops the head whenever downstream takes it.
  always @(negedge clk) begin : monitor
    int n;
    if (mon_en) begin
      n = exp_q.size();
      check("occupancy", occupancy, n);
      check("in_ready", in_ready, (n < 2));
      check("out_valid", out_valid, (n != 0));
      check("stall_cnt", stall_cnt, stall_m);
      check("drop_cnt", drop_cnt, drop_m);
      if (n != 0) begin
        check("out_data", out_data, exp_q[0].d);
        check("out_ctrl", out_ctrl, exp_q[0].c);
        if (out_ready) begin
          exp_q.delete(0);
          pops++;
        end
      end else begin
        check("out_data_nop", out_data, 0);
        check("out_ctrl_nop", out_ctrl, 0);
      end
    end
  end

  // Model update at the clock edge: accepts, flushes, resets and counts.
  always @(posedge clk) begin : model
    int   occ;
    ent_t e;
    occ = exp_q.size() + (pops - pops_seen);
    pops_seen = pops;
    if (!nrst) begin
      exp_q.delete();
      stall_m = 0;
      drop_m  = 0;
    end else begin
      if (occ > 0 && !out_ready && stall_m < CMAX) stall_m++;
      if (flush) begin
        drop_m = drop_m + exp_q.size();
        if (drop_m > CMAX) drop_m = CMAX;
        exp_q.delete();
      end else if (in_valid && occ < 2) begin
        e.d = in_data;
        e.c = in_ctrl;
        exp_q.push_back(e);
      end
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic r, input logic f, input logic n);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
    flush     = f;
    nrst      = n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;

    // Reset then stream
    for (int i = 1; i <= 3; i++) drive(1, i, 16'h00A5, 1, 0, 1);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 1, 0, 1);

    // Backpressure fill; 12 must be refused
    for (int i = 10; i <= 12; i++) drive(1, i, 16'h00A5, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);

    // Drain
    repeat (3) drive(0, 0, 0, 1, 0, 1);

    // Flush from SKID with a same-cycle input
    drive(1, 20, 16'h0011, 0, 0, 1);
    drive(1, 21, 16'h0022, 0, 0, 1);
    drive(1, 22, 16'h0033, 0, 1, 1);
    repeat (2) drive(0, 0, 0, 1, 0, 1);

    // Stall counter saturation
    drive(1, 30, 16'h0044, 0, 0, 1);
    repeat (20) drive(0, 0, 0, 0, 0, 1);

    // Reset mid-stall from SKID
    drive(1, 31, 16'h0055, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);

    // Randomized traffic with occasional flush and reset
    repeat (3000) begin
      drive(($urandom % 4) != 0, {$urandom, $urandom, $urandom}, CW'($urandom),
            ($urandom % 3) != 0, ($urandom % 25) == 0, ($urandom % 200) != 0);
    end

    repeat (3) drive(0, 0, 0, 1, 0, 1);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
